bcd_counter: RTL and testbench

- Multi-digit BCD up/down counter that consumes the slow square wave produced by the clock divider.
- Detects each rising edge of that wave in the system clock domain and advances the count by one per edge.
- Supports synchronous parallel load, count enable and direction control.
- Provides a one-cycle terminal-count pulse for cascading or display logic.

---
 rtl/bcd_counter_pkg.sv | 14 +
 rtl/bcd_counter_digit.sv | 29 ++
 rtl/bcd_counter.sv | 62 ++++++
 tb/tb_bcd_counter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_pkg.sv
// Shared BCD digit definitions for the multi-digit BCD counter.
package bcd_counter_pkg;

  localparam int unsigned BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  typedef logic [BCD_W-1:0] bcd_t;

  function automatic bcd_t bcd_clamp(input bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_counter_digit.sv
// One BCD digit of the ripple chain: load with clamp, or step up/down on carry-in.
module bcd_digit
  import bcd_counter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic cin,
  input  logic up_down,
  input  logic load,
  input  bcd_t ld_digit,
  output bcd_t digit,
  output logic cout
);

  // cout means this digit wraps on the current step, so the next digit moves too.
  assign cout = cin & (up_down ? (digit == BCD_MAX) : (digit == BCD_MIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= '0;
    end else if (load) begin
      digit <= bcd_clamp(ld_digit);
    end else if (cin) begin
      if (up_down) digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
      else         digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter stepped by rising edges of the divided tick.
module bcd_counter
  import bcd_counter_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter bit          WRAP   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_in,
  input  logic                    en,
  input  logic                    up_down,
  input  logic                    load,
  input  logic [4*DIGITS-1:0]     load_value,
  output logic [4*DIGITS-1:0]     count,
  output logic                    tc
);

  logic              tick_q;
  logic              step;
  logic              at_term;
  logic              tc_next;
  logic [DIGITS:0]   carry;

  always_ff @(posedge clk) begin
    tick_q <= tick_in;
  end

  assign step = tick_in & ~tick_q & en;

  always_comb begin
    at_term = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (count[i*BCD_W +: BCD_W] != (up_down ? BCD_MAX : BCD_MIN)) at_term = 1'b0;
    end
  end

  // Saturating mode blocks the step at the chain input instead of gating the
  // top cout, which would form a loop back through the carry chain.
  assign carry[0] = step & (WRAP | ~at_term);

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .cin      (carry[g]),
      .up_down  (up_down),
      .load     (load),
      .ld_digit (load_value[g*BCD_W +: BCD_W]),
      .digit    (count[g*BCD_W +: BCD_W]),
      .cout     (carry[g+1])
    );
  end

  assign tc_next = WRAP ? carry[DIGITS] : (step & at_term);

  always_ff @(posedge clk) begin
    if (rst || load) tc <= 1'b0;
    else             tc <= tc_next;
  end

endmodule

// File: tb/tb_bcd_counter.sv
// Bench for bcd_counter: wrapping and saturating instances against an integer model.
module tb_bcd_counter;

  localparam int D = 4;
  localparam int MAXV = 9999;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick_in = 1'b1;
  logic          en = 1'b1;
  logic          up_down = 1'b1;
  logic          load = 1'b0;
  logic [4*D-1:0] load_value = '0;
  logic [4*D-1:0] count_w, count_s;
  logic          tc_w, tc_s;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // model state: index 0 = wrapping instance, 1 = saturating instance
  int mv[2];
  bit mtc[2];
  bit tick_prev = 1'b0;

  always #5 clk = ~clk;

  bcd_counter #(.DIGITS(D), .WRAP(1'b1)) dut_w (
    .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .up_down(up_down),
    .load(load), .load_value(load_value), .count(count_w), .tc(tc_w)
  );

  bcd_counter #(.DIGITS(D), .WRAP(1'b0)) dut_s (
    .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .up_down(up_down),
    .load(load), .load_value(load_value), .count(count_s), .tc(tc_s)
  );

  function automatic logic [4*D-1:0] to_bcd(input int v);
    logic [4*D-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int load_to_int(input logic [4*D-1:0] lv);
    int v, w, d;
    v = 0;
    w = 1;
    for (int i = 0; i < D; i++) begin
      d = int'(lv[4*i +: 4]);
      if (d > 9) d = 9;
      v = v + d * w;
      w = w * 10;
    end
    return v;
  endfunction

  always @(posedge clk) begin
    bit stp;
    stp = tick_in && !tick_prev && en;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mv[k] = 0; mtc[k] = 1'b0;
      end else if (load) begin
        mv[k] = load_to_int(load_value); mtc[k] = 1'b0;
      end else if (stp) begin
        mtc[k] = 1'b0;
        if (up_down) begin
          if (mv[k] == MAXV) begin mtc[k] = 1'b1; mv[k] = (k == 0) ? 0 : MAXV; end
          else mv[k] = mv[k] + 1;
        end else begin
          if (mv[k] == 0) begin mtc[k] = 1'b1; mv[k] = (k == 0) ? MAXV : 0; end
          else mv[k] = mv[k] - 1;
        end
      end else begin
        mtc[k] = 1'b0;
      end
    end
    tick_prev = tick_in;
    if (rst) chk_en = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (count_w !== to_bcd(mv[0]) || tc_w !== mtc[0]) begin
        errors++;
        $display("FAIL model_wrap t=%0t count=%h tc=%b required count=%h tc=%b",
                 $time, count_w, tc_w, to_bcd(mv[0]), mtc[0]);
      end
      checks++;
      if (count_s !== to_bcd(mv[1]) || tc_s !== mtc[1]) begin
        errors++;
        $display("FAIL model_sat t=%0t count=%h tc=%b required count=%h tc=%b",
                 $time, count_s, tc_s, to_bcd(mv[1]), mtc[1]);
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic edge_tick();
    tick_in = 1'b0; cyc();
    tick_in = 1'b1; cyc();
  endtask

  task automatic lit(input string name, input logic [4*D-1:0] c, input logic t,
                     input logic [4*D-1:0] ec, input logic et);
    checks++;
    if (c !== ec || t !== et) begin
      errors++;
      $display("FAIL %s count=%h tc=%b required count=%h tc=%b", name, c, t, ec, et);
    end
  endtask

  task automatic do_load(input logic [4*D-1:0] v);
    load = 1'b1; load_value = v; cyc();
    load = 1'b0;
  endtask

  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(3);
    lit("reset_hold_tick", count_w, tc_w, 16'h0000, 1'b0);

    for (int i = 1; i <= 12; i++) begin
      edge_tick();
      if (i == 10) lit("count_10", count_w, tc_w, 16'h0010, 1'b0);
    end
    lit("count_12", count_w, tc_w, 16'h0012, 1'b0);

    tick_in = 1'b0; cyc();
    do_load(16'h9999);
    lit("load_9999", count_s, tc_s, 16'h9999, 1'b0);
    tick_in = 1'b1; cyc();
    lit("wrap_up", count_w, tc_w, 16'h0000, 1'b1);
    lit("sat_up", count_s, tc_s, 16'h9999, 1'b1);
    cyc();
    lit("wrap_up_tc_drop", count_w, tc_w, 16'h0000, 1'b0);

    tick_in = 1'b0; up_down = 1'b0;
    do_load(16'h0100);
    tick_in = 1'b1; cyc();
    lit("down_0100", count_w, tc_w, 16'h0099, 1'b0);

    tick_in = 1'b0;
    do_load(16'h0000);
    tick_in = 1'b1; cyc();
    lit("wrap_down", count_w, tc_w, 16'h9999, 1'b1);
    lit("sat_down", count_s, tc_s, 16'h0000, 1'b1);
    cyc();
    lit("sat_down_tc_drop", count_s, tc_s, 16'h0000, 1'b0);

    tick_in = 1'b0; up_down = 1'b1; cyc();
    load = 1'b1; load_value = 16'h12F5; tick_in = 1'b1; cyc();
    load = 1'b0;
    lit("load_vs_step", count_w, tc_w, 16'h1295, 1'b0);
    cyc(3);
    lit("step_dropped", count_w, tc_w, 16'h1295, 1'b0);

    en = 1'b0;
    for (int i = 0; i < 3; i++) edge_tick();
    lit("en_off", count_w, tc_w, 16'h1295, 1'b0);
    en = 1'b1; cyc(2);
    lit("en_on_high", count_w, tc_w, 16'h1295, 1'b0);
    edge_tick();
    lit("en_next_edge", count_w, tc_w, 16'h1296, 1'b0);

    tick_in = 1'b0; cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1);
  end

endmodule
